seq_det_sequencer: RTL and testbench

Feeds parallel words, MSB first, into the shared 1101 Mealy sequence detector as a serial bit stream, and accumulates the detector's hits. It sits between a valid/ready word source and the detector: it drives the detector's `x` and the detector's reset, samples `z`, and reports per-word and running hit counts. Back-to-back words form one gap-free bit stream, so overlapping matches across word boundaries are detected.

---
 rtl/seq_det_sequencer.sv | 123 ++++++++++++
 tb/tb_seq_det_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sequencer.sv
// seq_det_sequencer: shifts words MSB-first into the shared 1101 detector and tallies its hits.
// Optional SEQDET_RESTART_EN: pulse the detector reset for one cycle before every word.
module seq_det_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          clr_cnt,
    output logic                          det_x,
    output logic                          det_valid,
    output logic                          det_rst_n,
    input  logic                          det_z,
    output logic                          busy,
    output logic                          word_done,
    output logic [$clog2(DATA_W+1)-1:0]   word_hits,
    output logic [CNT_W-1:0]              match_cnt
);
    localparam int unsigned HW = $clog2(DATA_W + 1);
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SEQDET_RESTART_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_RST} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [HW-1:0]       hcnt_q, hcnt_d;
    logic [HW-1:0]       word_hits_q, word_hits_d;
    logic                word_done_q, word_done_d;
    logic [CNT_W-1:0]    match_q, match_d;
    logic                det_rst_q, det_rst_d;
    logic                last_bit, take, hit;

    assign last_bit  = (state_q == ST_SHIFT) && (bit_q == BW'(DATA_W - 1));
    assign in_ready  = (state_q == ST_IDLE) || last_bit;
    assign take      = in_valid && in_ready;
    assign det_valid = (state_q == ST_SHIFT);
    assign busy      = (state_q != ST_IDLE);
    assign hit       = det_valid && det_z;
    // The register drains to zero by the end of each word, so IDLE drives x=0.
    assign det_x     = sreg_q[DATA_W-1];
    assign det_rst_n = det_rst_q;
    assign word_done = word_done_q;
    assign word_hits = word_hits_q;
    assign match_cnt = match_q;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_d       = bit_q;
        hcnt_d      = hcnt_q;
        word_hits_d = word_hits_q;
        word_done_d = 1'b0;
        det_rst_d   = 1'b1;
        match_d     = match_q;

        case (state_q)
            ST_SHIFT: begin
                sreg_d = sreg_q << 1;
                bit_d  = bit_q + BW'(1);
                hcnt_d = hcnt_q + HW'(hit);
                if (last_bit) begin
                    word_done_d = 1'b1;
                    word_hits_d = hcnt_q + HW'(hit);
                    bit_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
`ifdef SEQDET_RESTART_EN
            ST_RST:  state_d = ST_SHIFT;
`endif
            default: state_d = ST_IDLE;
        endcase

        // A load on the last bit overrides the return to IDLE for a gap-free stream.
        if (take) begin
            sreg_d = in_data;
            bit_d  = '0;
            hcnt_d = '0;
`ifdef SEQDET_RESTART_EN
            state_d   = ST_RST;
            det_rst_d = 1'b0;
`else
            state_d   = ST_SHIFT;
`endif
        end

        if (clr_cnt) begin
            match_d = '0;
        end else if (hit && (match_q != '1)) begin
            match_d = match_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            bit_q       <= '0;
            hcnt_q      <= '0;
            word_hits_q <= '0;
            word_done_q <= 1'b0;
            match_q     <= '0;
            det_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_q       <= bit_d;
            hcnt_q      <= hcnt_d;
            word_hits_q <= word_hits_d;
            word_done_q <= word_done_d;
            match_q     <= match_d;
            det_rst_q   <= det_rst_d;
        end
    end
endmodule

// File: tb/tb_seq_det_sequencer.sv
// Self-checking bench for seq_det_sequencer with a behavioural 1101 detector and queue-based reference model.
module tb_seq_det_sequencer;
    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 4;
    localparam int unsigned HB   = $clog2(DW + 1);
    localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef SEQDET_RESTART_EN
    localparam int unsigned LAT = 2;   // cycles from accept edge to first data bit
`else
    localparam int unsigned LAT = 1;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, clr_cnt = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, det_x, det_valid, det_rst_n, det_z, busy, word_done;
    logic [HB-1:0] word_hits;
    logic [CW-1:0] match_cnt;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    seq_det_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clr_cnt(clr_cnt), .det_x(det_x), .det_valid(det_valid),
        .det_rst_n(det_rst_n), .det_z(det_z), .busy(busy), .word_done(word_done),
        .word_hits(word_hits), .match_cnt(match_cnt)
    );

    // Shared detector: remembers the last three bits seen since its reset.
    logic [2:0]  d_hist = '0;
    int unsigned d_n = 0;
    always @(posedge clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            d_hist <= '0;
            d_n    <= 0;
        end else begin
            d_hist <= {d_hist[1:0], det_x};
            if (d_n < 3) d_n <= d_n + 1;
        end
    end
    assign det_z = (d_n >= 3) && (d_hist == 3'b110) && det_x;

    // Reference model: pending bits of the word in flight, and the detector's view of the stream.
    bit          m_q[$];
    bit          m_stream[$];
    bit          m_rstc, m_drst, e_done;
    int unsigned m_acc, e_hits, e_match;
    bit          drv_v, drv_c;
    logic [DW-1:0] drv_d;

    function automatic bit m_ready(); return !m_rstc && (m_q.size() <= 1); endfunction
    function automatic bit m_valid(); return !m_rstc && (m_q.size() > 0); endfunction
    function automatic bit m_busy();  return m_rstc || (m_q.size() > 0); endfunction
    function automatic bit m_x();     return m_valid() ? m_q[0] : 1'b0; endfunction
    function automatic bit m_z();
        int n = m_stream.size();
        if (n < 3) return 1'b0;
        return m_stream[n-3] && m_stream[n-2] && !m_stream[n-1] && m_x();
    endfunction

    function automatic void model_reset();
        m_q.delete(); m_stream.delete();
        m_rstc = 0; m_drst = 0; e_done = 0;
        m_acc = 0; e_hits = 0; e_match = 0;
    endfunction

    function automatic void model_edge();
        bit tr  = drv_v && m_ready();
        bit hit = m_valid() && m_z();
        if (!m_drst) m_stream.delete();
        else begin
            m_stream.push_back(m_x());
            if (m_stream.size() > 4) void'(m_stream.pop_front());
        end
        e_done = 1'b0;
        if (m_rstc) m_rstc = 1'b0;
        else if (m_q.size() > 0) begin
            if (hit) m_acc++;
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                e_done = 1'b1;
                e_hits = m_acc;
            end
        end
        if (drv_c) e_match = 0;
        else if (hit && e_match < CMAX) e_match++;
        if (tr) begin
            m_acc = 0;
            for (int i = DW - 1; i >= 0; i--) m_q.push_back(drv_d[i]);
`ifdef SEQDET_RESTART_EN
            m_rstc = 1'b1;
`endif
        end
        m_drst = !m_rstc;
    endfunction

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit c);
        drv_v = v; drv_d = d; drv_c = c;
        in_valid = v; in_data = d; clr_cnt = c;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0; drv_v = 0; drv_c = 0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, det_x, det_valid, busy, word_done, det_rst_n} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got %b want 100000", {in_ready, det_x, det_valid, busy, word_done, det_rst_n});
        end
        checks++;
        if (word_hits !== HB'(0) || match_cnt !== CW'(0)) begin
            errors++;
            $display("FAIL reset_counts got hits=%0d cnt=%0d want 0 0", word_hits, match_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, '0, 1'b0);
        checks++;
        if (det_rst_n !== 1'b0) begin
            errors++; $display("FAIL det_rst_hold got %b want 0", det_rst_n);
        end
        advance();
        drive(1'b0, '0, 1'b0);
        checks++;
        if (det_rst_n !== 1'b1) begin
            errors++; $display("FAIL det_rst_rise got %b want 1", det_rst_n);
        end
        advance();
    endtask

    task automatic test_single();
        logic [DW-1:0] w = 8'hDA;
        bit seen = 0;
        for (int unsigned n = 0; n <= 20 && !seen; n++) begin
            drive(n == 0, w, 1'b0);
            if (n >= LAT && n < LAT + DW) begin
                checks++;
                if (det_valid !== 1'b1 || det_x !== w[DW-1-(n-LAT)]) begin
                    errors++;
                    $display("FAIL single_bit%0d got v=%b x=%b want 1 %b", n - LAT, det_valid, det_x, w[DW-1-(n-LAT)]);
                end
            end
            if (word_done === 1'b1) begin
                seen = 1;
                checks++;
                if (n != DW + LAT) begin
                    errors++; $display("FAIL single_latency got %0d want %0d", n, DW + LAT);
                end
                checks++;
                if (word_hits !== HB'(2) || match_cnt !== CW'(2)) begin
                    errors++; $display("FAIL single_hits got hits=%0d cnt=%0d want 2 2", word_hits, match_cnt);
                end
            end
            advance();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL single_timeout got no word_done want one");
        end
        drive(1'b0, '0, 1'b0);
        checks++;
        if (word_done !== 1'b0 || word_hits !== HB'(2)) begin
            errors++; $display("FAIL single_hold got done=%b hits=%0d want 0 2", word_done, word_hits);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        bit          sent2 = 0;
        int unsigned nd = 0;
        logic [HB-1:0] h[2];
        int unsigned t[2];
        for (int unsigned n = 0; n <= 40 && nd < 2; n++) begin
            bit give = (n == 0) || !sent2;
            drive(give, (n == 0) ? 8'h06 : 8'h80, 1'b0);
            if (n > 0 && word_done === 1'b1) begin
                h[nd] = word_hits; t[nd] = n;
                if (nd == 0) begin
                    checks++;
`ifdef SEQDET_RESTART_EN
                    if (det_rst_n !== 1'b0 || busy !== 1'b1) begin
                        errors++; $display("FAIL b2b_restart got rst_n=%b busy=%b want 0 1", det_rst_n, busy);
                    end
`else
                    if (det_valid !== 1'b1 || det_x !== 1'b1) begin
                        errors++; $display("FAIL b2b_gap got v=%b x=%b want 1 1", det_valid, det_x);
                    end
`endif
                end
                nd++;
            end
            if (n > 0 && give && m_ready()) sent2 = 1;
            advance();
        end
        checks++;
        if (nd != 2) begin
            errors++; $display("FAIL b2b_timeout got %0d word_done want 2", nd);
        end else begin
            checks++;
            if (t[0] != DW + LAT || t[1] != 2 * (DW + LAT) - 1) begin
                errors++; $display("FAIL b2b_timing got %0d,%0d want %0d,%0d", t[0], t[1], DW + LAT, 2 * (DW + LAT) - 1);
            end
            checks++;
`ifdef SEQDET_RESTART_EN
            if (h[0] !== HB'(0) || h[1] !== HB'(0)) begin
                errors++; $display("FAIL b2b_hits got %0d,%0d want 0,0", h[0], h[1]);
            end
`else
            if (h[0] !== HB'(0) || h[1] !== HB'(1)) begin
                errors++; $display("FAIL b2b_hits got %0d,%0d want 0,1", h[0], h[1]);
            end
`endif
        end
        repeat (3) begin drive(1'b0, '0, 1'b0); advance(); end
    endtask

    task automatic test_clr();
        bit seen = 0;
        for (int unsigned n = 0; n <= 20 && !seen; n++) begin
            drive(n == 0, 8'h0D, n == DW + LAT - 1);
            if (word_done === 1'b1) begin
                seen = 1;
                checks++;
                if (match_cnt !== CW'(0) || word_hits !== HB'(1)) begin
                    errors++; $display("FAIL clr_hit got cnt=%0d hits=%0d want 0 1", match_cnt, word_hits);
                end
            end
            advance();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL clr_timeout got no word_done want one");
        end
    endtask

    task automatic test_saturate();
        int unsigned sent = 0, nd = 0;
        for (int unsigned n = 0; n <= 200 && nd < 8; n++) begin
            drive(sent < 8, 8'hDA, 1'b0);
            if (sent < 8 && m_ready()) sent++;
            if (word_done === 1'b1) nd++;
            advance();
        end
        drive(1'b0, '0, 1'b0);
        checks++;
        if (nd != 8 || match_cnt !== CW'(CMAX) || word_hits !== HB'(2)) begin
            errors++; $display("FAIL saturate got words=%0d cnt=%0d hits=%0d want 8 %0d 2", nd, match_cnt, word_hits, CMAX);
        end
        advance();
        drive(1'b0, '0, 1'b1);
        advance();
        drive(1'b0, '0, 1'b0);
        checks++;
        if (match_cnt !== CW'(0)) begin
            errors++; $display("FAIL clr_only got %0d want 0", match_cnt);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        for (int unsigned n = 0; n < LAT + 4; n++) begin
            drive(n == 0, 8'hDA, 1'b0);
            advance();
        end
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({in_ready, det_x, det_valid, busy, word_done, det_rst_n} !== 6'b100000
            || word_hits !== HB'(0) || match_cnt !== CW'(0)) begin
            errors++;
            $display("FAIL midreset got flags=%b hits=%0d cnt=%0d want 100000 0 0",
                     {in_ready, det_x, det_valid, busy, word_done, det_rst_n}, word_hits, match_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int unsigned n = 0; n < 12; n++) begin
            drive(1'b0, '0, 1'b0);
            checks++;
            if (word_done !== 1'b0) begin
                errors++; $display("FAIL midreset_done got 1 want 0 at cycle %0d", n);
            end
            advance();
        end
        test_single();
    endtask

    task automatic test_random();
        for (int unsigned n = 0; n < 400; n++) begin
            drive(bit'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 15) == 0);
            checks++;
            if ({in_ready, busy, det_valid, det_rst_n, word_done} !== {m_ready(), m_busy(), m_valid(), m_drst, e_done}) begin
                errors++;
                $display("FAIL rnd_flags cycle %0d got %b want %b", n,
                         {in_ready, busy, det_valid, det_rst_n, word_done}, {m_ready(), m_busy(), m_valid(), m_drst, e_done});
            end
            if (!m_rstc) begin
                checks++;
                if (det_x !== m_x()) begin
                    errors++; $display("FAIL rnd_x cycle %0d got %b want %b", n, det_x, m_x());
                end
            end
            checks++;
            if (word_hits !== HB'(e_hits) || match_cnt !== CW'(e_match)) begin
                errors++;
                $display("FAIL rnd_counts cycle %0d got hits=%0d cnt=%0d want %0d %0d", n, word_hits, match_cnt, e_hits, e_match);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clr();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
